// File: rtl/lms_pkg.sv
// Shared widths, FSM state encoding and saturation helper for the LMS error stage.
package lms_pkg;

    localparam int NTAP  = 16;
    localparam int DW    = 14;
    localparam int WW    = 32;
    localparam int WFRAC = 16;
    localparam int ACCW  = 50;
    localparam int PW    = WW + DW;
    localparam int CW    = $clog2(NTAP);

    localparam logic signed [ACCW-1:0] SAT_MAX = 50'sd8191;
    localparam logic signed [ACCW-1:0] SAT_MIN = -50'sd8192;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        ERR,
        WAIT,
        UPD
    } state_t;

    // Clamp a wide signed value into the 14-bit sample range.
    function automatic logic signed [DW-1:0] sat14(input logic signed [ACCW-1:0] v);
        if (v > SAT_MAX) begin
            return 14'sh1FFF;
        end else if (v < SAT_MIN) begin
            return 14'sh2000;
        end else begin
            return v[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/lms_mac.sv
// Registered multiply-accumulate: one weight x tap product per enabled cycle.
module lms_mac
    import lms_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [WW-1:0]   w,
    input  logic signed [DW-1:0]   x,
    output logic signed [ACCW-1:0] acc
);

    logic signed [PW-1:0] prod;

    assign prod = w * x;

    // Accumulator: clear wins over enable; product is sign-extended to the full width.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACCW'(prod);
        end
    end

endmodule

// File: rtl/lms_error_calc.sv
// LMS upstream stage: tap delay line, time-shared FIR MAC, error and update strobe.
module lms_error_calc
    import lms_pkg::*;
#(
    parameter int DIV_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic signed [DW-1:0] x_in,
    input  logic signed [DW-1:0] d_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [WW-1:0] weight_in_0,
    input  logic signed [WW-1:0] weight_in_1,
    input  logic signed [WW-1:0] weight_in_2,
    input  logic signed [WW-1:0] weight_in_3,
    input  logic signed [WW-1:0] weight_in_4,
    input  logic signed [WW-1:0] weight_in_5,
    input  logic signed [WW-1:0] weight_in_6,
    input  logic signed [WW-1:0] weight_in_7,
    input  logic signed [WW-1:0] weight_in_8,
    input  logic signed [WW-1:0] weight_in_9,
    input  logic signed [WW-1:0] weight_in_10,
    input  logic signed [WW-1:0] weight_in_11,
    input  logic signed [WW-1:0] weight_in_12,
    input  logic signed [WW-1:0] weight_in_13,
    input  logic signed [WW-1:0] weight_in_14,
    input  logic signed [WW-1:0] weight_in_15,
    output logic signed [DW-1:0] reff_0,
    output logic signed [DW-1:0] reff_1,
    output logic signed [DW-1:0] reff_2,
    output logic signed [DW-1:0] reff_3,
    output logic signed [DW-1:0] reff_4,
    output logic signed [DW-1:0] reff_5,
    output logic signed [DW-1:0] reff_6,
    output logic signed [DW-1:0] reff_7,
    output logic signed [DW-1:0] reff_8,
    output logic signed [DW-1:0] reff_9,
    output logic signed [DW-1:0] reff_10,
    output logic signed [DW-1:0] reff_11,
    output logic signed [DW-1:0] reff_12,
    output logic signed [DW-1:0] reff_13,
    output logic signed [DW-1:0] reff_14,
    output logic signed [DW-1:0] reff_15,
    output logic signed [DW-1:0] e,
    output logic signed [DW-1:0] y_out,
    output logic                 y_valid,
    output logic                 weight_cal_state
);

    // Last WAIT count; unused when the divider has zero latency.
    localparam logic [7:0] WAIT_LAST = 8'((DIV_LAT > 0) ? DIV_LAT - 1 : 0);

    state_t                  state;
    state_t                  state_nx;
    logic [CW-1:0]           tap;
    logic [7:0]              wait_cnt;
    logic signed [DW-1:0]    dly [NTAP];
    logic signed [WW-1:0]    wts [NTAP];
    logic signed [DW-1:0]    d_lat;
    logic signed [ACCW-1:0]  acc;
    logic signed [DW-1:0]    y_sat;
    logic signed [DW:0]      diff;
    logic signed [DW-1:0]    e_sat;
    logic                    accept;
    logic                    mac_clr;
    logic                    mac_en;

    assign wts[0]  = weight_in_0;
    assign wts[1]  = weight_in_1;
    assign wts[2]  = weight_in_2;
    assign wts[3]  = weight_in_3;
    assign wts[4]  = weight_in_4;
    assign wts[5]  = weight_in_5;
    assign wts[6]  = weight_in_6;
    assign wts[7]  = weight_in_7;
    assign wts[8]  = weight_in_8;
    assign wts[9]  = weight_in_9;
    assign wts[10] = weight_in_10;
    assign wts[11] = weight_in_11;
    assign wts[12] = weight_in_12;
    assign wts[13] = weight_in_13;
    assign wts[14] = weight_in_14;
    assign wts[15] = weight_in_15;

    assign reff_0  = dly[0];
    assign reff_1  = dly[1];
    assign reff_2  = dly[2];
    assign reff_3  = dly[3];
    assign reff_4  = dly[4];
    assign reff_5  = dly[5];
    assign reff_6  = dly[6];
    assign reff_7  = dly[7];
    assign reff_8  = dly[8];
    assign reff_9  = dly[9];
    assign reff_10 = dly[10];
    assign reff_11 = dly[11];
    assign reff_12 = dly[12];
    assign reff_13 = dly[13];
    assign reff_14 = dly[14];
    assign reff_15 = dly[15];

    assign accept = in_valid && in_ready;

    // Tap mux feeds the shared MAC; weights only matter while mac_en is high.
    lms_mac u_mac (
        .clk  (clk),
        .rstn (rstn),
        .clr  (mac_clr),
        .en   (mac_en),
        .w    (wts[tap]),
        .x    (dly[tap]),
        .acc  (acc)
    );

    // Drop the Q16.16 fraction (floor), then error at one extra bit so d - y never wraps.
    assign y_sat = sat14(acc >>> WFRAC);
    assign diff  = {d_lat[DW-1], d_lat} - {y_sat[DW-1], y_sat};
    assign e_sat = sat14(ACCW'(diff));

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = MAC;
            MAC:  if (tap == CW'(NTAP - 1)) state_nx = ERR;
            ERR:  state_nx = (DIV_LAT == 0) ? UPD : WAIT;
            WAIT: if (wait_cnt == WAIT_LAST) state_nx = UPD;
            UPD:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs and MAC controls.
    always_comb begin
        in_ready         = (state == IDLE);
        weight_cal_state = (state == UPD);
        mac_en           = (state == MAC);
        mac_clr          = accept;
    end

    // Tap counter walks 0..15 during MAC and wraps back to 0 on the last tap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tap <= '0;
        end else if (accept) begin
            tap <= '0;
        end else if (mac_en) begin
            tap <= tap + CW'(1);
        end
    end

    // Divider-latency counter, restarted in ERR.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (state == ERR) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Delay line and desired-sample latch move only on accept edges.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NTAP; k++) dly[k] <= '0;
            d_lat <= '0;
        end else if (accept) begin
            for (int k = NTAP - 1; k > 0; k--) dly[k] <= dly[k-1];
            dly[0] <= x_in;
            d_lat  <= d_in;
        end
    end

    // Result registers load on the edge leaving ERR; y_valid pulses for that one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_out   <= '0;
            e       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= (state == ERR);
            if (state == ERR) begin
                y_out <= y_sat;
                e     <= e_sat;
            end
        end
    end

endmodule
